mmio_console_arbiter: RTL

//   Shares one byte-wide console/UART TX channel between NCORE cores. Each core's MMIO stores
//   (dbus address bit 31 set) are presented here instead of going straight to the console.

---
 rtl/mmio_console_arbiter_if.sv | 42 ++++
 rtl/mmio_console_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mmio_console_arbiter_if.sv
// rtl/mmio_console_arbiter_if.sv - core request and console byte channel bundle for the console arbiter
interface mmio_console_arbiter_if #(
    parameter int NCORE = 4
);
    localparam int CORE_W = $clog2(NCORE);

    // Per-core MMIO store requests; core k occupies bits [32k+31:32k] of addr/data
    logic [NCORE-1:0]       req_valid_i;
    logic [NCORE*32-1:0]    req_addr_i;
    logic [NCORE*32-1:0]    req_data_i;
    logic [NCORE-1:0]       req_ready_o;

    // Byte channel toward the console
    logic                   tx_valid_o;
    logic [7:0]             tx_data_o;
    logic [CORE_W-1:0]      tx_core_o;
    logic                   tx_ready_i;

    // Arbiter side
    modport slave (
        input  req_valid_i,
        input  req_addr_i,
        input  req_data_i,
        output req_ready_o,
        output tx_valid_o,
        output tx_data_o,
        output tx_core_o,
        input  tx_ready_i
    );

    // Cores plus console side
    modport master (
        output req_valid_i,
        output req_addr_i,
        output req_data_i,
        input  req_ready_o,
        input  tx_valid_o,
        input  tx_data_o,
        input  tx_core_o,
        output tx_ready_i
    );
endinterface

// File: rtl/mmio_console_arbiter.sv
// rtl/mmio_console_arbiter.sv - round-robin sharing of one console byte channel between cores
module mmio_console_arbiter #(
    parameter int          NCORE     = 4,
    parameter logic [31:0] FINI_CODE = 32'h00020000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mmio_console_arbiter_if.slave   bus,
    output logic [NCORE-1:0]        fini_o,
    output logic                    all_fini_o,
    output logic [NCORE-1:0]        err_o
);
    localparam int CORE_W = $clog2(NCORE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CORE_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [CORE_W-1:0]  tx_core_q, tx_core_d;
    logic [NCORE-1:0]   fini_q, fini_d;
    logic [NCORE-1:0]   err_q, err_d;
    logic               all_fini_q, all_fini_d;

    logic               gnt_valid;
    logic [CORE_W-1:0]  gnt_idx;
    logic [CORE_W-1:0]  cand;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_data;
    logic [NCORE-1:0]   req_ready;
    logic               unused_addr_bits;

    // Round-robin search starting just after the last granted core; scanning from the
    // farthest offset down lets the nearest requester overwrite earlier hits.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int off = NCORE; off >= 1; off--) begin
            cand = CORE_W'((int'(rr_ptr_q) + off) % NCORE);
            if (bus.req_valid_i[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Route the granted core's address and data to the request decoder
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NCORE; k++) begin
            if (gnt_idx == CORE_W'(k)) begin
                sel_addr = bus.req_addr_i[k*32 +: 32];
                sel_data = bus.req_data_i[k*32 +: 32];
            end
        end
    end

    // Only the MMIO-space bit of the address matters to this block
    assign unused_addr_bits = &{1'b0, sel_addr[30:0]};

    // Next-state and accept logic: IDLE accepts one request, SEND holds the byte for the console
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_core_d  = tx_core_q;
        fini_d     = fini_q;
        err_d      = err_q;
        all_fini_d = &fini_q;
        req_ready  = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    req_ready = {{(NCORE-1){1'b0}}, 1'b1} << gnt_idx;
                    rr_ptr_d  = gnt_idx;
                    if (!sel_addr[31]) begin
                        err_d[gnt_idx] = 1'b1;
                    end else if (sel_data == FINI_CODE) begin
                        fini_d[gnt_idx] = 1'b1;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = sel_data[7:0];
                        tx_core_d  = gnt_idx;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (bus.tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any byte still waiting in SEND
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= CORE_W'(NCORE - 1);
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_core_q  <= '0;
            fini_q     <= '0;
            err_q      <= '0;
            all_fini_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_core_q  <= tx_core_d;
            fini_q     <= fini_d;
            err_q      <= err_d;
            all_fini_q <= all_fini_d;
        end
    end

    // Accept pulses are suppressed while reset is held so nothing is consumed then
    assign bus.req_ready_o = rst_i ? '0 : req_ready;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_core_o   = tx_core_q;
    assign fini_o          = fini_q;
    assign all_fini_o      = all_fini_q;
    assign err_o           = err_q;
endmodule
